addr_gen_multi: RTL and testbench

- Parametrised successor to the two-counter DSP address generator.
- Holds NUM_CNT independent base counters, each with its own start value, increment and wrap limit, plus a shared series offset.
- Emits a pipelined RAM address: base of the selected counter + series offset + per-access pointer offset, with a valid strobe.
- Sits between the DSP sequencer (drives select/pointer/counter controls) and the coefficient/state block RAMs.

---
 rtl/addr_gen_multi.sv | 146 ++++++++++++++
 tb/tb_addr_gen_multi.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_gen_multi.sv
// Multi-counter DSP address generator: NUM_CNT base counters + shared series offset + pointer offset, 3-stage pipeline.
// Optional macro ADDR_GEN_MULTI_OVF_FLAG_EN adds the addr_ovf carry flag output.

module addr_gen_cnt #(
    parameter int                    ADDR_WIDTH = 9,
    parameter logic [ADDR_WIDTH-1:0] START      = '0,
    parameter logic [ADDR_WIDTH-1:0] INC        = ADDR_WIDTH'(1),
    parameter logic [ADDR_WIDTH-1:0] LIMIT      = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  rld,
    output logic [ADDR_WIDTH-1:0] cnt
);
    // one extra bit so the limit compare sees the true sum
    logic [ADDR_WIDTH:0] nxt;
    assign nxt = {1'b0, cnt} + {1'b0, INC};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      cnt <= START;
        else if (rld)                    cnt <= START;
        else if (inc) begin
            if (nxt >= {1'b0, LIMIT})    cnt <= START;
            else                         cnt <= nxt[ADDR_WIDTH-1:0];
        end
    end
endmodule

module addr_gen_multi #(
    parameter int                              ADDR_WIDTH = 9,
    parameter int                              NUM_CNT    = 4,
    parameter int                              SEL_WIDTH  = 2,
    parameter int                              OFS_WIDTH  = 4,
    parameter logic [NUM_CNT*ADDR_WIDTH-1:0]   ADDR_START = '0,
    parameter logic [NUM_CNT*ADDR_WIDTH-1:0]   ADDR_INC   = {NUM_CNT{ADDR_WIDTH'(1)}},
    parameter logic [NUM_CNT*ADDR_WIDTH-1:0]   ADDR_LIMIT = {NUM_CNT{ADDR_WIDTH'(511)}},
    parameter logic [ADDR_WIDTH-1:0]           SERIES_INC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CNT-1:0]    cnt_inc,
    input  logic [NUM_CNT-1:0]    cnt_rst,
    input  logic                  ptr_valid,
    input  logic [SEL_WIDTH-1:0]  ptr_sel,
    input  logic [OFS_WIDTH-1:0]  ptr_ofs,
    input  logic                  series_inc,
    input  logic                  series_rst,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  addr_valid
`ifdef ADDR_GEN_MULTI_OVF_FLAG_EN
    ,
    output logic                  addr_ovf
`endif
);
    localparam int STAGES = 3;
`ifdef ADDR_GEN_MULTI_OVF_FLAG_EN
    localparam int SUM_W = ADDR_WIDTH + 1;
`else
    localparam int SUM_W = ADDR_WIDTH;
`endif

    logic [NUM_CNT-1:0][ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0]              base_sel, base_r, sum_r, series_r;
    logic [OFS_WIDTH-1:0]               ofs_r1, ofs_r2;
    logic                               series_inc_r, series_rst_r;
    logic [STAGES:1]                    vld_pipe;
    logic [SUM_W-1:0]                   s2_full, s3_full;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            addr_gen_cnt #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .START      (ADDR_START[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                .INC        (ADDR_INC[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                .LIMIT      (ADDR_LIMIT[gi*ADDR_WIDTH +: ADDR_WIDTH])
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (cnt_inc[gi]),
                .rld   (cnt_rst[gi]),
                .cnt   (cnt[gi])
            );
        end
    endgenerate

    // selects past the last counter fall through to a zero base
    always_comb begin
        base_sel = '0;
        for (int i = 0; i < NUM_CNT; i++)
            if (ptr_sel == SEL_WIDTH'(i)) base_sel = cnt[i];
    end

    // series controls take effect one cycle after they are sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            series_inc_r <= 1'b0;
            series_rst_r <= 1'b0;
            series_r     <= '0;
        end else begin
            series_inc_r <= series_inc;
            series_rst_r <= series_rst;
            if (series_rst_r)      series_r <= '0;
            else if (series_inc_r) series_r <= series_r + SERIES_INC;
        end
    end

    assign s2_full = SUM_W'(base_r) + SUM_W'(series_r);
    assign s3_full = SUM_W'(sum_r) + SUM_W'(ofs_r2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            base_r   <= '0;
            ofs_r1   <= '0;
            sum_r    <= '0;
            ofs_r2   <= '0;
            addr_out <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], ptr_valid};
            base_r   <= base_sel;
            ofs_r1   <= ptr_ofs;
            sum_r    <= s2_full[ADDR_WIDTH-1:0];
            ofs_r2   <= ofs_r1;
            addr_out <= s3_full[ADDR_WIDTH-1:0];
        end
    end

    assign addr_valid = vld_pipe[STAGES];

`ifdef ADDR_GEN_MULTI_OVF_FLAG_EN
    logic c2_r;
    // a carry out of either adder flags the request; gated so it never outlives addr_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c2_r     <= 1'b0;
            addr_ovf <= 1'b0;
        end else begin
            c2_r     <= s2_full[SUM_W-1];
            addr_ovf <= vld_pipe[2] & (c2_r | s3_full[SUM_W-1]);
        end
    end
`endif

endmodule

// File: tb/tb_addr_gen_multi.sv
// Self-checking bench for addr_gen_multi: directed scenarios plus random traffic against a cycle-indexed reference model.
module tb_addr_gen_multi;
    localparam int AW = 9;
    localparam int NC = 4;

    logic          clk, rst_n;
    logic [NC-1:0] cnt_inc, cnt_rst;
    logic          ptr_valid;
    logic [2:0]    ptr_sel;
    logic [3:0]    ptr_ofs;
    logic          series_inc, series_rst;
    logic [AW-1:0] addr_out;
    logic          addr_valid;
`ifdef ADDR_GEN_MULTI_OVF_FLAG_EN
    logic          addr_ovf;
`endif

    addr_gen_multi #(
        .ADDR_WIDTH (AW),
        .NUM_CNT    (NC),
        .SEL_WIDTH  (3),
        .OFS_WIDTH  (4),
        .ADDR_START ({9'd400, 9'd0,   9'd16, 9'd0}),
        .ADDR_INC   ({9'd100, 9'd1,   9'd8,  9'd1}),
        .ADDR_LIMIT ({9'd511, 9'd511, 9'd40, 9'd511}),
        .SERIES_INC (9'd64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_inc    (cnt_inc),
        .cnt_rst    (cnt_rst),
        .ptr_valid  (ptr_valid),
        .ptr_sel    (ptr_sel),
        .ptr_ofs    (ptr_ofs),
        .series_inc (series_inc),
        .series_rst (series_rst),
        .addr_out   (addr_out),
        .addr_valid (addr_valid)
`ifdef ADDR_GEN_MULTI_OVF_FLAG_EN
        ,
        .addr_ovf   (addr_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run, n_fail;

    // reference model: counter values, series value and per-cycle request history
    int ST[NC]   = '{0, 16, 0, 400};
    int INCV[NC] = '{1, 8, 1, 100};
    int LIM[NC]  = '{511, 40, 511, 511};
    int m_cnt[NC];
    int m_ser;
    bit m_sinc_d, m_srst_d;
    int rq_v[4096], rq_base[4096], rq_ofs[4096], ser_at[4096];
    int cyc;
    int exp_v, exp_a, exp_o;

    task automatic idle_inputs();
        cnt_inc = '0; cnt_rst = '0; ptr_valid = 1'b0; ptr_sel = '0; ptr_ofs = '0;
        series_inc = 1'b0; series_rst = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_cnt[i] = ST[i];
        m_ser = 0; m_sinc_d = 0; m_srst_d = 0;
        for (int i = 0; i < 3; i++) begin
            rq_v[i] = 0; rq_base[i] = 0; rq_ofs[i] = 0; ser_at[i] = 0;
        end
        cyc = 3; exp_v = 0; exp_a = 0; exp_o = 0;
    endtask

    // one clock: record this cycle's request, advance the model, then predict what is visible now
    task automatic step();
        int s, idx, c, c1, total, nxt;
        s   = int'(ptr_sel);
        idx = cyc % 4096;
        rq_v[idx]    = int'(ptr_valid);
        rq_base[idx] = (s < NC) ? m_cnt[s] : 0;
        rq_ofs[idx]  = int'(ptr_ofs);
        ser_at[idx]  = m_ser;
        for (int i = 0; i < NC; i++) begin
            if (cnt_rst[i]) m_cnt[i] = ST[i];
            else if (cnt_inc[i]) begin
                nxt = m_cnt[i] + INCV[i];
                m_cnt[i] = (nxt >= LIM[i]) ? ST[i] : nxt;
            end
        end
        if (m_srst_d)      m_ser = 0;
        else if (m_sinc_d) m_ser = (m_ser + 64) % 512;
        m_sinc_d = series_inc;
        m_srst_d = series_rst;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        c     = (cyc - 3) % 4096;
        c1    = (cyc - 2) % 4096;
        total = rq_base[c] + ser_at[c1] + rq_ofs[c];
        exp_v = rq_v[c];
        exp_a = total % 512;
        exp_o = (exp_v != 0 && total > 511) ? 1 : 0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic hard_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        release_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        n_run++; if (addr_out !== 9'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", addr_out); end
        n_run++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", addr_valid); end
`ifdef ADDR_GEN_MULTI_OVF_FLAG_EN
        n_run++; if (addr_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", addr_ovf); end
`endif
        release_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            n_run++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %0b expected 0", addr_valid); end
            n_run++; if (addr_out !== 9'd0) begin n_fail++; $display("FAIL reset_idle_addr: got %0d expected 0", addr_out); end
        end
    endtask

    task automatic test_basic();
        hard_reset();
        ptr_valid = 1'b1; ptr_sel = 3'd2; ptr_ofs = 4'd5;
        step();
        idle_inputs();
        step();
        n_run++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %0b expected 0", addr_valid); end
        step();
        n_run++; if (addr_out !== 9'd5) begin n_fail++; $display("FAIL basic_addr: got %0d expected 5", addr_out); end
        n_run++; if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b expected 1", addr_valid); end
        step();
        n_run++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_after: got %0b expected 0", addr_valid); end
    endtask

    task automatic test_wrap();
        int want[3] = '{24, 32, 16};
        hard_reset();
        for (int k = 0; k < 3; k++) begin
            idle_inputs(); cnt_inc = 4'b0010;
            step();
            idle_inputs(); ptr_valid = 1'b1; ptr_sel = 3'd1;
            step();
            idle_inputs();
            step();
            step();
            n_run++; if (addr_out !== 9'(want[k]) || addr_valid !== 1'b1) begin
                n_fail++; $display("FAIL wrap_%0d: got %0d/%0b expected %0d/1", k, addr_out, addr_valid, want[k]);
            end
            n_run++; if (addr_out !== 9'(exp_a)) begin n_fail++; $display("FAIL wrap_model_%0d: got %0d expected %0d", k, addr_out, exp_a); end
        end
    endtask

    task automatic test_priority();
        hard_reset();
        cnt_inc = 4'b0001;
        for (int k = 0; k < 7; k++) step();
        cnt_inc = 4'b0001; cnt_rst = 4'b0001; ptr_valid = 1'b1; ptr_sel = 3'd0; ptr_ofs = 4'd0;
        step();
        cnt_inc = '0; cnt_rst = '0;
        step();
        ptr_valid = 1'b0;
        step();
        n_run++; if (addr_out !== 9'd7) begin n_fail++; $display("FAIL prio_sample: got %0d expected 7", addr_out); end
        step();
        n_run++; if (addr_out !== 9'd0 || addr_valid !== 1'b1) begin
            n_fail++; $display("FAIL prio_reload: got %0d/%0b expected 0/1", addr_out, addr_valid);
        end
    endtask

    task automatic test_series();
        hard_reset();
        series_inc = 1'b1;
        step();
        series_inc = 1'b0; ptr_valid = 1'b1; ptr_sel = 3'd0;
        step();
        ptr_valid = 1'b0;
        step();
        step();
        n_run++; if (addr_out !== 9'd64 || addr_valid !== 1'b1) begin
            n_fail++; $display("FAIL series_inc: got %0d/%0b expected 64/1", addr_out, addr_valid);
        end
        series_inc = 1'b1; series_rst = 1'b1;
        step();
        series_inc = 1'b0; series_rst = 1'b0; ptr_valid = 1'b1; ptr_sel = 3'd0;
        step();
        ptr_valid = 1'b0;
        step();
        step();
        n_run++; if (addr_out !== 9'd0 || addr_valid !== 1'b1) begin
            n_fail++; $display("FAIL series_rst: got %0d/%0b expected 0/1", addr_out, addr_valid);
        end
    endtask

    task automatic test_ovf();
        hard_reset();
        ptr_valid = 1'b1; ptr_sel = 3'd3; ptr_ofs = 4'd15;
        step();
        idle_inputs();
        step();
        step();
        n_run++; if (addr_out !== 9'd415) begin n_fail++; $display("FAIL ovf_415: got %0d expected 415", addr_out); end
`ifdef ADDR_GEN_MULTI_OVF_FLAG_EN
        n_run++; if (addr_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_flag_lo: got %0b expected 0", addr_ovf); end
`endif
        cnt_inc = 4'b1000;
        step();
        idle_inputs(); ptr_valid = 1'b1; ptr_sel = 3'd3; ptr_ofs = 4'd15;
        step();
        idle_inputs();
        step();
        step();
        n_run++; if (addr_out !== 9'd3) begin n_fail++; $display("FAIL ovf_wrap: got %0d expected 3", addr_out); end
`ifdef ADDR_GEN_MULTI_OVF_FLAG_EN
        n_run++; if (addr_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag_hi: got %0b expected 1", addr_ovf); end
        step();
        n_run++; if (addr_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_not_sticky: got %0b expected 0", addr_ovf); end
`endif
    endtask

    task automatic test_back_to_back();
        hard_reset();
        for (int k = 0; k < 16; k++) begin
            ptr_valid  = 1'b1;
            ptr_sel    = 3'($urandom_range(0, 7));
            ptr_ofs    = 4'(k);
            cnt_inc    = 4'($urandom);
            series_inc = 1'($urandom);
            step();
            if (k >= 2) begin
                n_run++; if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_%0d: got %0b expected 1", k, addr_valid); end
                n_run++; if (addr_out !== 9'(exp_a)) begin n_fail++; $display("FAIL b2b_addr_%0d: got %0d expected %0d", k, addr_out, exp_a); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        hard_reset();
        for (int k = 0; k < 6; k++) begin
            ptr_valid = 1'b1; ptr_sel = 3'($urandom_range(0, 3)); ptr_ofs = 4'($urandom_range(1, 15));
            series_inc = 1'b1;
            step();
        end
        rst_n = 1'b0;
        #1;
        n_run++; if (addr_out !== 9'd0 || addr_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_async: got %0d/%0b expected 0/0", addr_out, addr_valid);
        end
        idle_inputs();
        release_reset();
        ptr_valid = 1'b1; ptr_sel = 3'd1; ptr_ofs = 4'd3;
        step();
        n_run++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_flush1: got %0b expected 0", addr_valid); end
        step();
        n_run++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_flush2: got %0b expected 0", addr_valid); end
        step();
        n_run++; if (addr_valid !== 1'b1 || addr_out !== 9'd19) begin
            n_fail++; $display("FAIL reset_mid_new: got %0d/%0b expected 19/1", addr_out, addr_valid);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        hard_reset();
        for (int k = 0; k < 1500; k++) begin
            cnt_inc    = 4'($urandom);
            cnt_rst    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            ptr_valid  = 1'($urandom);
            ptr_sel    = 3'($urandom);
            ptr_ofs    = 4'($urandom);
            series_inc = 1'($urandom);
            series_rst = ($urandom_range(0, 15) == 0);
            step();
            n_run++; if (addr_valid !== 1'(exp_v)) begin n_fail++; $display("FAIL rand_valid_%0d: got %0b expected %0d", k, addr_valid, exp_v); end
            n_run++; if (addr_out !== 9'(exp_a)) begin n_fail++; $display("FAIL rand_addr_%0d: got %0d expected %0d", k, addr_out, exp_a); end
`ifdef ADDR_GEN_MULTI_OVF_FLAG_EN
            n_run++; if (addr_ovf !== 1'(exp_o)) begin n_fail++; $display("FAIL rand_ovf_%0d: got %0b expected %0d", k, addr_ovf, exp_o); end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        n_run = 0; n_fail = 0;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_priority();
        test_series();
        test_ovf();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
